// File: rtl/systolic_setup.sv
`default_nettype none
// ============================================================================
// Module      : systolic_setup
// Description : Input skew stage for a LANES x LANES systolic array. Each
//               lane j of the A and B buffer words is passed through a delay
//               line of exactly j+1 registers. This turns one buffer word per
//               cycle into the diagonal wavefront the array edges expect.
//               Bubble and idle cycles still occupy a slot, so the A/B skew
//               alignment is never disturbed. A drain counter reports data
//               still in flight.
// Ports       : clk_i     - clock, rising-edge active
//               rst_i     - asynchronous active-high reset
//               ensys_i   - systolic input enable (aligned with read data)
//               bubble_i  - inject a zero/invalid slot this cycle
//               flush_i   - synchronous clear of every in-flight stage
//               dina_i    - buffer A word, lane j at [j*DATA_WIDTH +: DATA_WIDTH]
//               dinb_i    - buffer B word, same packing
//               a_o/b_o   - skewed operands to the array's left/top edges
//               va_o/vb_o - per-lane valids for a_o/b_o
//               busy_o    - data still in flight through the skew lines
// Revision    : 1.0 - initial release
// ============================================================================
module systolic_setup #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          ensys_i,
    input  logic                          bubble_i,
    input  logic                          flush_i,
    input  logic [LANES*DATA_WIDTH-1:0]   dina_i,
    input  logic [LANES*DATA_WIDTH-1:0]   dinb_i,
    output logic [LANES*DATA_WIDTH-1:0]   a_o,
    output logic [LANES*DATA_WIDTH-1:0]   b_o,
    output logic [LANES-1:0]              va_o,
    output logic [LANES-1:0]              vb_o,
    output logic                          busy_o
);

    localparam int                 c_CNT_W      = $clog2(LANES + 1);
    localparam logic [c_CNT_W-1:0] c_DRAIN_LOAD = c_CNT_W'(LANES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE    = c_CNT_W'(1);

    // An element is accepted only on an enabled, non-bubble cycle. Every
    // other cycle still pushes a zero/invalid slot into each line.
    logic w_acc;
    assign w_acc = ensys_i & ~bubble_i;

    // ------------------------------------------------------------------------
    // Per-lane delay lines. The A and B data of a lane see the same accept
    // history, so one valid line per lane drives both va_o and vb_o.
    // ------------------------------------------------------------------------
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        logic [DATA_WIDTH-1:0] r_a [0:j];
        logic [DATA_WIDTH-1:0] r_b [0:j];
        logic                  r_v [0:j];

        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                for (int k = 0; k <= j; k++) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                    r_v[k] <= 1'b0;
                end
            end else if (flush_i) begin
                // Flush wins over a concurrent enable: that input is dropped.
                for (int k = 0; k <= j; k++) begin
                    r_a[k] <= '0;
                    r_b[k] <= '0;
                    r_v[k] <= 1'b0;
                end
            end else begin
                r_a[0] <= w_acc ? dina_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_b[0] <= w_acc ? dinb_i[j*DATA_WIDTH +: DATA_WIDTH] : '0;
                r_v[0] <= w_acc;
                for (int k = 1; k <= j; k++) begin
                    r_a[k] <= r_a[k-1];
                    r_b[k] <= r_b[k-1];
                    r_v[k] <= r_v[k-1];
                end
            end
        end

        assign a_o[j*DATA_WIDTH +: DATA_WIDTH] = r_a[j];
        assign b_o[j*DATA_WIDTH +: DATA_WIDTH] = r_b[j];
        assign va_o[j]                         = r_v[j];
        assign vb_o[j]                         = r_v[j];
    end

    // ------------------------------------------------------------------------
    // Drain counter: reloaded on every enabled cycle (bubbles included, as
    // they still occupy the longest line), then counts down to zero.
    // ------------------------------------------------------------------------
    logic [c_CNT_W-1:0] r_drain_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_drain_cnt <= '0;
        end else if (flush_i) begin
            r_drain_cnt <= '0;
        end else if (ensys_i) begin
            r_drain_cnt <= c_DRAIN_LOAD;
        end else if (r_drain_cnt != '0) begin
            r_drain_cnt <= r_drain_cnt - c_CNT_ONE;
        end
    end

    assign busy_o = (r_drain_cnt != '0);

endmodule
`default_nettype wire

// File: tb/tb_systolic_setup.sv
`default_nettype none
// ============================================================================
// Module      : tb_systolic_setup
// Description : Self-checking bench for systolic_setup. Every cycle's
//               effective input is logged by edge number. The output of
//               lane j after edge n is the logged element from edge n-j,
//               unless a flush or reset occurred at or after that edge.
//               Busy is high while fewer than LANES edges have passed since
//               the last surviving enabled edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_setup;

    localparam int c_DW    = 16;
    localparam int c_LANES = 8;
    localparam int c_W     = c_LANES * c_DW;
    localparam int c_LOG   = 4096;

    logic             clk_i = 1'b0;
    logic             rst_i;
    logic             ensys_i;
    logic             bubble_i;
    logic             flush_i;
    logic [c_W-1:0]   dina_i;
    logic [c_W-1:0]   dinb_i;
    logic [c_W-1:0]   a_o;
    logic [c_W-1:0]   b_o;
    logic [c_LANES-1:0] va_o;
    logic [c_LANES-1:0] vb_o;
    logic             busy_o;

    systolic_setup #(
        .DATA_WIDTH (c_DW),
        .LANES      (c_LANES)
    ) u_dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .ensys_i  (ensys_i),
        .bubble_i (bubble_i),
        .flush_i  (flush_i),
        .dina_i   (dina_i),
        .dinb_i   (dinb_i),
        .a_o      (a_o),
        .b_o      (b_o),
        .va_o     (va_o),
        .vb_o     (vb_o),
        .busy_o   (busy_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model state ----------------
    logic [c_W-1:0]     log_a [0:c_LOG-1];
    logic [c_W-1:0]     log_b [0:c_LOG-1];
    logic               log_v [0:c_LOG-1];
    int                 n_edge   = 0;     // number of rising edges seen
    int                 last_clr = 0;     // last edge that wiped the pipeline
    int                 last_ens = -1000; // last surviving enabled edge

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [c_W-1:0] obs, input logic [c_W-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, n_edge, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [c_W-1:0]     ea;
        logic [c_W-1:0]     eb;
        logic [c_LANES-1:0] ev;
        logic               ebusy;
        ea = '0;
        eb = '0;
        ev = '0;
        for (int j = 0; j < c_LANES; j++) begin
            int m;
            m = n_edge - j;
            if (m > last_clr && m >= 1) begin
                ea[j*c_DW +: c_DW] = log_a[m][j*c_DW +: c_DW];
                eb[j*c_DW +: c_DW] = log_b[m][j*c_DW +: c_DW];
                ev[j]              = log_v[m];
            end
        end
        ebusy = (last_ens > last_clr) && (n_edge - last_ens < c_LANES);
        check({tag, ".a"},    a_o,  ea);
        check({tag, ".b"},    b_o,  eb);
        check({tag, ".va"},   c_W'(va_o),   c_W'(ev));
        check({tag, ".vb"},   c_W'(vb_o),   c_W'(ev));
        check({tag, ".busy"}, c_W'(busy_o), c_W'(ebusy));
    endtask

    // One clock: log what the DUT sees at the edge, then check on the falling edge.
    task automatic tick(input string tag);
        @(posedge clk_i);
        n_edge++;
        if (n_edge >= c_LOG) begin
            $display("FAIL log_overflow: edge %0d exceeds %0d", n_edge, c_LOG);
            $fatal(1, "log overflow");
        end
        if (rst_i || flush_i) begin
            last_clr = n_edge;
        end else begin
            logic acc;
            acc = ensys_i & ~bubble_i;
            log_a[n_edge] = acc ? dina_i : '0;
            log_b[n_edge] = acc ? dinb_i : '0;
            log_v[n_edge] = acc;
            if (ensys_i) last_ens = n_edge;
        end
        @(negedge clk_i);
        check_outputs(tag);
    endtask

    task automatic rand_words();
        for (int j = 0; j < c_LANES; j++) begin
            dina_i[j*c_DW +: c_DW] = c_DW'($urandom);
            dinb_i[j*c_DW +: c_DW] = c_DW'($urandom);
        end
    endtask

    task automatic idle(input int cycles, input string tag);
        ensys_i  = 1'b0;
        bubble_i = 1'b0;
        flush_i  = 1'b0;
        for (int i = 0; i < cycles; i++) tick(tag);
    endtask

    initial begin
        rst_i    = 1'b1;
        ensys_i  = 1'b0;
        bubble_i = 1'b0;
        flush_i  = 1'b0;
        dina_i   = '0;
        dinb_i   = '0;

        // Reset state: everything reads zero while reset is held.
        #2;
        check_outputs("reset_async");
        tick("reset");
        tick("reset");
        rst_i = 1'b0;
        idle(2, "post_reset");

        // Single word: A lanes hold 1..8, B lanes hold 0x10+j.
        for (int j = 0; j < c_LANES; j++) begin
            dina_i[j*c_DW +: c_DW] = c_DW'(j + 1);
            dinb_i[j*c_DW +: c_DW] = c_DW'(16 + j);
        end
        ensys_i = 1'b1;
        tick("single");
        idle(10, "single_drain");

        // Stream of 4 words followed by 4 bubble cycles.
        for (int t = 0; t < 4; t++) begin
            rand_words();
            ensys_i = 1'b1;
            tick("stream");
        end
        for (int t = 0; t < 4; t++) begin
            rand_words();
            ensys_i  = 1'b1;
            bubble_i = 1'b1;
            tick("bubble");
        end
        idle(10, "stream_drain");

        // Full-scale data back to back.
        dina_i  = {c_LANES{16'hFFFF}};
        dinb_i  = {c_LANES{16'hFFFF}};
        ensys_i = 1'b1;
        tick("full_ffff");
        dina_i  = {c_LANES{16'h8000}};
        dinb_i  = {c_LANES{16'h8000}};
        tick("full_8000");
        idle(10, "full_drain");

        // Flush together with an enable three cycles into a stream.
        for (int t = 0; t < 3; t++) begin
            rand_words();
            ensys_i = 1'b1;
            tick("pre_flush");
        end
        dina_i  = {c_LANES{16'hDEAD}};
        dinb_i  = {c_LANES{16'hBEEF}};
        flush_i = 1'b1;
        tick("flush");
        flush_i = 1'b0;
        idle(10, "post_flush");

        // Asynchronous reset mid-stream, released with the enable low.
        for (int t = 0; t < 3; t++) begin
            rand_words();
            ensys_i = 1'b1;
            tick("pre_rst");
        end
        #2;
        rst_i = 1'b1;
        #1;
        last_clr = n_edge;
        check_outputs("rst_mid_async");
        tick("rst_mid");
        ensys_i = 1'b0;
        rst_i   = 1'b0;
        idle(10, "post_rst");

        // Randomized traffic with occasional bubbles and flushes.
        for (int i = 0; i < 600; i++) begin
            rand_words();
            ensys_i  = ($urandom_range(0, 3) != 0);
            bubble_i = ($urandom_range(0, 4) == 0);
            flush_i  = ($urandom_range(0, 31) == 0);
            tick("random");
        end
        idle(12, "final_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/systolic_setup.md
SYSTOLIC_SETUP -- requirements
Module: systolic_setup

Interface
REQ-001 The parameter list SHALL be: DATA_WIDTH, default 16, width of one matrix element.
REQ-002 The parameter list SHALL include: LANES, default 8, array dimension and lane count per buffer word.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port clk_i  input  1  clock; all state changes on its rising edge.
REQ-005 Port rst_i  input  1  asynchronous active-high reset.
REQ-006 Port ensys_i  input  1  systolic input enable, aligned with buffer read data.
REQ-007 Port bubble_i  input  1  inject zeros instead of buffer data this cycle.
REQ-008 Port flush_i  input  1  synchronous clear of all in-flight stages.
REQ-009 Port dina_i  input  LANES*DATA_WIDTH  buffer A read word; lane j is bits [j*DATA_WIDTH +: DATA_WIDTH].
REQ-010 Port dinb_i  input  LANES*DATA_WIDTH  buffer B read word; same lane packing.
REQ-011 Port a_o  output  LANES*DATA_WIDTH  skewed row operands to the array's left edge.
REQ-012 Port b_o  output  LANES*DATA_WIDTH  skewed column operands to the array's top edge.
REQ-013 Port va_o  output  LANES  per-lane valid for a_o.
REQ-014 Port vb_o  output  LANES  per-lane valid for b_o.
REQ-015 Port busy_o  output  1  data still in flight through the skew lines.

Function
REQ-016 Per-cycle accept qualifier SHALL be acc = ensys_i & ~bubble_i.
REQ-017 Effective element x_j SHALL be lane j of dina_i (resp. dinb_i) when acc = 1, else 0.
REQ-018 Lane j SHALL be a delay line of exactly j+1 registers, so a_o/b_o lane j equals x_j sampled j+1 cycles earlier.
REQ-019 va_o[j] and vb_o[j] SHALL equal acc sampled j+1 cycles earlier, delayed alongside the data.
REQ-020 All delay lines SHALL shift every cycle, with no stall, irrespective of ensys_i.
REQ-021 When ensys_i = 0, zeros with valid = 0 SHALL enter every line.
REQ-022 A bubble cycle (ensys_i = 1, bubble_i = 1) SHALL enter zero data with valid = 0 and SHALL occupy a slot, so skew alignment is preserved.
REQ-023 A drain counter of width clog2(LANES+1) SHALL be loaded with LANES on any edge where ensys_i = 1.
REQ-024 Otherwise the drain counter SHALL decrement if nonzero and hold at zero.
REQ-025 busy_o SHALL be high exactly when the drain counter is nonzero.
REQ-026 flush_i = 1 SHALL zero every delay register, every valid bit and the drain counter on the next edge.
REQ-027 When flush_i and ensys_i are both high, flush SHALL win and that cycle's input SHALL be discarded.
REQ-028 There SHALL be no arithmetic on data; values pass bit-exact, with no sign handling.
REQ-029 Outputs SHALL be driven directly from registers, with no combinational path from any input to any output.

Reset
REQ-030 While rst_i is high, all delay registers, valid bits and the drain counter SHALL be 0.
REQ-031 During reset, a_o, b_o, va_o, vb_o and busy_o SHALL all read 0.
REQ-032 Reset asserted mid-stream SHALL clear in-flight data immediately, with no partial output after release.
REQ-033 The first edge after rst_i falls SHALL behave as a normal cycle.

Verification
REQ-034 Single word: dina_i lanes = 1..8, ensys_i high for one cycle -> a_o lane j = j+1 with va_o[j] = 1 exactly at cycle j+1 after input; zero otherwise.
REQ-035 Stream: k = 4 consecutive words (ensys_i = 1), then 4 bubble cycles -> each lane shows 4 valid values followed by 4 zero/invalid slots; busy_o falls 8 cycles after the last ensys_i.
REQ-036 Alignment: A word w_t and B word w_t entered at the same cycle -> a_o lane j and b_o lane j present the element of the same t at identical cycles.
REQ-037 Flush: flush_i with ensys_i = 1 three cycles into a stream -> next cycle all outputs, valids and busy_o are 0, and the concurrent input never appears.
REQ-038 Reset mid-stream: rst_i asserted asynchronously between edges -> outputs go 0 without waiting for a clock edge; after release with ensys_i = 0, outputs stay 0.
REQ-039 Full-scale data: all lanes 16'hFFFF then 16'h8000 back-to-back -> the values appear unmodified on every lane with the correct skew.
